// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - state_e    : responder FSM states (IDLE / WAIT / RESP)
//   - BE_ALL     : all four byte lanes enabled
//   - CNT_W      : width of the wait-state counter
//   - LAT_MAX    : largest wait-state count the counter can hold
//   - ERR_NONE / ERR_FAULT : values driven on rsp_err
//   - is_pow2()  : helper for the elaboration-time parameter checks
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_ALL    = 4'hF;
  localparam int         CNT_W     = 4;
  localparam int         LAT_MAX   = (1 << CNT_W) - 1;
  localparam logic       ERR_NONE  = 1'b0;
  localparam logic       ERR_FAULT = 1'b1;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port word RAM with per-byte write enables. Read and write share one
// synchronous edge; the read port is registered (read-before-write on the
// same address). Contents are never reset. Storage is split into one byte
// array per lane so each lane maps onto its own RAM column.
//
// Ports:
//   clk      in  : rising-edge clock
//   en_i     in  : access enable for this edge
//   we_i     in  : 1 = write the enabled lanes
//   be_i     in  : byte enables, bit i covers bits [8i+7:8i]
//   addr_i   in  : word index
//   wdata_i  in  : write data, lane-aligned
//   rdata_o  out : registered read data (updates only on enabled edges)
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];
      logic [7:0] rdata_q;

      always_ff @(posedge clk) begin
        if (en_i) begin
          if (we_i && be_i[gi]) begin
            mem_lane[addr_i] <= wdata_i[8*gi +: 8];
          end
          rdata_q <= mem_lane[addr_i];
        end
      end

      assign rdata_o[8*gi +: 8] = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the core's load/store channel. Accepts one
// request at a time, waits LATENCY cycles, performs a byte-enabled write or
// a word read against the local RAM and presents the response until the
// core takes it.
//
// Build option: DMEM_MISALIGN_CHECK_EN -- when defined, requests with
// addr[1:0] != 0 complete as faults; otherwise the low address bits are
// ignored. Out-of-range checking is always present.
//
// Ports:
//   clk        in  : rising-edge clock
//   resetn     in  : asynchronous active-low reset
//   req_valid  in  : request present
//   req_ready  out : responder can accept a request (registered)
//   req_addr   in  : byte address
//   req_we     in  : 1 = write, 0 = read
//   req_wdata  in  : write data, lane-aligned
//   req_be     in  : byte enables
//   rsp_valid  out : response present
//   rsp_ready  in  : core accepts the response
//   rsp_rdata  out : read data, zero for writes and faults
//   rsp_err    out : access fault
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  generate
    if (LATENCY < 0 || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 0..15");
    end
    if (!is_pow2(DEPTH_WORDS) || DEPTH_WORDS < 4) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be a power of two >= 4");
    end
  endgenerate

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [AW-1:0]      idx_q;
  logic               we_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               fault_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic               rd_ok_q;

  logic               fault_d;
  logic               access_d;
  logic               ram_en_d;
  logic               ram_we_d;
  logic [31:0]        ram_rdata;

  // Fault classification is done on the incoming address so only the word
  // index needs to be kept for the access.
`ifdef DMEM_MISALIGN_CHECK_EN
  assign fault_d = ({1'b0, req_addr} >= ADDR_LIMIT) || (req_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign fault_d = ({1'b0, req_addr} >= ADDR_LIMIT);
`endif

  // The RAM is touched only on the final wait-state edge and never for a
  // faulting request; since state_q is cleared asynchronously, a reset in
  // WAIT can never let a write through.
  assign access_d = (state_q == ST_WAIT) && (cnt_q == '0);
  assign ram_en_d = access_d && !fault_q;
  assign ram_we_d = ram_en_d && we_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en_d),
    .we_i    (ram_we_d),
    .be_i    (be_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      fault_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_NONE;
      rd_ok_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Also raises ready on the first edge after reset release.
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            idx_q       <= req_addr[AW+1:2];
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            fault_q     <= fault_d;
            cnt_q       <= CNT_W'(LATENCY);
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= fault_q ? ERR_FAULT : ERR_NONE;
            rd_ok_q     <= !we_q && !fault_q;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_NONE;
            rd_ok_q     <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= ERR_NONE;
          rd_ok_q     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // The RAM read register is only loaded on the access edge, so it stays
  // stable for the whole RESP phase; rd_ok_q zeroes it for writes/faults.
  assign rsp_rdata = rd_ok_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests;
  int fails;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return #1 after the acceptance edge.
  task automatic accept_req(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, " req_ready before accept"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
  endtask

  // Full transaction: latency, response values, optional backpressure,
  // and post-handshake state.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    accept_req(tag, we, addr, wdata, be);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, " hold rdata"}, rsp_rdata, exp_rdata);
      check({tag, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " post rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " post req_ready"}, {31'd0, req_ready}, 32'd1);
    $display("[TB] txn %s we=%0b addr=0x%08h wdata=0x%08h be=%b exp_rdata=0x%08h exp_err=%0b",
             tag, we, addr, wdata, be, exp_rdata, exp_err);
  endtask

  initial begin
    int guard;
    tests     = 0;
    fails     = 0;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_we    = 1'b0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    rsp_ready = 1'b0;

    // Reset: two cycles low, all outputs zero, ready one edge after release.
    tick();
    tick();
    check("reset req_ready", {31'd0, req_ready}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    resetn = 1'b1;
    #1;
    check("release req_ready low", {31'd0, req_ready}, 32'd0);
    tick();
    check("release req_ready high", {31'd0, req_ready}, 32'd1);
    $display("[TB] reset sequence done");

    // Full-word write then read.
    txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
    txn("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);

    // Partial write over all-ones.
    txn("wr20 ones", 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b0);
    txn("wr20 part", 1'b1, 32'h20, 32'h11223344, 4'b0101, 0, 32'h0, 1'b0);
    txn("rd20 part", 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'hFF22FF44, 1'b0);

    // be=0 write is a legal no-op.
    txn("wr20 be0", 1'b1, 32'h20, 32'h00000000, 4'h0, 0, 32'h0, 1'b0);
    txn("rd20 be0", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hFF22FF44, 1'b0);

    // Backpressure: five cycles without rsp_ready.
    txn("rd10 bp", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEEF, 1'b0);

    // Out-of-range accesses; word 0 must not be aliased.
    txn("wr00", 1'b1, 32'h0, 32'h12345678, 4'hF, 0, 32'h0, 1'b0);
    txn("rd400", 1'b0, 32'h400, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    txn("wr400", 1'b1, 32'h400, 32'hAAAAAAAA, 4'hF, 0, 32'h0, 1'b1);
    txn("rd00", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h12345678, 1'b0);
    txn("rdFFC", 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0, 32'h0, 1'b1);

`ifdef DMEM_MISALIGN_CHECK_EN
    txn("wr22 mis", 1'b1, 32'h22, 32'h55667788, 4'hF, 0, 32'h0, 1'b1);
    txn("rd20 mis", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hFF22FF44, 1'b0);
    txn("rd13 mis", 1'b0, 32'h13, 32'h0, 4'h0, 0, 32'h0, 1'b1);
`else
    txn("wr22 lsb", 1'b1, 32'h22, 32'h55667788, 4'hF, 0, 32'h0, 1'b0);
    txn("rd20 lsb", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h55667788, 1'b0);
    txn("rd13 lsb", 1'b0, 32'h13, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
`endif

    // Reset during WAIT aborts the write.
    txn("wr30 zero", 1'b1, 32'h30, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    accept_req("wr30 abort", 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    resetn = 1'b0;
    #1;
    check("wait-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("wait-reset req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    $display("[TB] reset asserted during WAIT of write to 0x30");
    txn("rd30", 1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h0, 1'b0);

    // Reset during RESP keeps the committed write.
    accept_req("wr34 resp", 1'b1, 32'h34, 32'h5A5AA5A5, 4'hF);
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      tick();
      guard++;
    end
    check("resp-reset reached RESP", {31'd0, rsp_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    check("resp-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("resp-reset rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    $display("[TB] reset asserted during RESP of write to 0x34");
    txn("rd34", 1'b0, 32'h34, 32'h0, 4'h0, 0, 32'h5A5AA5A5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

endmodule
